// File: rtl/palette_pkg.sv
// Shared constants for the palette lookup block: default widths, background colour
// and the power-up palette contents.
// Latency: n/a (package). Backpressure: n/a.
// Contents: ID_W_DEF, COLOR_W_DEF, BG_COLOR_DEF, DEFAULT_PAL, default_color().
package palette_pkg;

  localparam int          ID_W_DEF     = 4;
  localparam int          COLOR_W_DEF  = 12;
  localparam logic [11:0] BG_COLOR_DEF = 12'h111;

  // Power-up colours for entries 1..8 (4:4:4 RGB); every other entry gets the background.
  localparam logic [8:1][11:0] DEFAULT_PAL = {
    12'hd00, 12'hf00, 12'hdd0, 12'hff0,
    12'h0c0, 12'h0f0, 12'hccc, 12'hfff
  };

  function automatic logic [11:0] default_color(input int unsigned idx, input logic [11:0] bg);
    logic [3:0] k;
    k = idx[3:0];
    if (idx >= 1 && idx <= 8) return DEFAULT_PAL[k];
    else                      return bg;
  endfunction

endpackage

// File: rtl/palette_bank.sv
// Palette register array: one write port, one combinational read port, whole-array load.
// Latency: write/load take effect at the clock edge; read is combinational.
// Backpressure: none, every write/load is accepted in the cycle it is presented.
// Ports: clk/rst_n; wr_en/wr_addr/wr_data/wr_blink write port; load_en/load_color/load_blink
//        parallel load (wins over a write); rd_addr -> rd_color/rd_blink; all_color/all_blink
//        expose the full array for parallel copy into another bank.
module palette_bank
  import palette_pkg::*;
#(
  parameter int                 ID_W     = ID_W_DEF,
  parameter int                 COLOR_W  = COLOR_W_DEF,
  parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'(BG_COLOR_DEF)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic [ID_W-1:0]                     wr_addr,
  input  logic [COLOR_W-1:0]                  wr_data,
  input  logic                                wr_blink,
  input  logic                                load_en,
  input  logic [2**ID_W-1:0][COLOR_W-1:0]     load_color,
  input  logic [2**ID_W-1:0]                  load_blink,
  input  logic [ID_W-1:0]                     rd_addr,
  output logic [COLOR_W-1:0]                  rd_color,
  output logic                                rd_blink,
  output logic [2**ID_W-1:0][COLOR_W-1:0]     all_color,
  output logic [2**ID_W-1:0]                  all_blink
);

  logic [2**ID_W-1:0][COLOR_W-1:0] color_q;
  logic [2**ID_W-1:0]              blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**ID_W; i++) begin
        color_q[i] <= COLOR_W'(default_color(i, 12'(BG_COLOR)));
        blink_q[i] <= 1'b0;
      end
    end else if (load_en) begin
      color_q <= load_color;
      blink_q <= load_blink;
    end else if (wr_en) begin
      color_q[wr_addr] <= wr_data;
      blink_q[wr_addr] <= wr_blink;
    end
  end

  assign rd_color  = color_q[rd_addr];
  assign rd_blink  = blink_q[rd_addr];
  assign all_color = color_q;
  assign all_blink = blink_q;

endmodule

// File: rtl/palette_lut.sv
// Colour-index to RGB lookup with double-buffered palette swapped on frame boundaries, plus blink.
// Latency: 2 cycles from pix_valid_i to color_valid_o, one lookup per cycle.
// Backpressure: none; the pipeline never stalls and writes/commits are always accepted.
// Ports: pix_valid_i/pix_id_i lookup in, color_valid_o/color_o result out; wr_* shadow write;
//        commit_i requests a swap at the next frame_start_i; pending_o shows a swap is outstanding.
module palette_lut
  import palette_pkg::*;
#(
  parameter int                 ID_W      = ID_W_DEF,
  parameter int                 COLOR_W   = COLOR_W_DEF,
  parameter int                 BLINK_DIV = 30,
  parameter logic [COLOR_W-1:0] BG_COLOR  = COLOR_W'(BG_COLOR_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid_i,
  input  logic [ID_W-1:0]    pix_id_i,
  output logic [COLOR_W-1:0] color_o,
  output logic               color_valid_o,
  input  logic               wr_en_i,
  input  logic [ID_W-1:0]    wr_addr_i,
  input  logic [COLOR_W-1:0] wr_data_i,
  input  logic               wr_blink_i,
  input  logic               commit_i,
  input  logic               frame_start_i,
  output logic               pending_o
);

  localparam logic [7:0] CNT_MAX = 8'(BLINK_DIV - 1);

  logic                            s1_vld;
  logic [ID_W-1:0]                 s1_id;
  logic                            pending_q;
  logic [7:0]                      blink_cnt;
  logic                            blink_phase;
  logic                            swap;

  logic [2**ID_W-1:0][COLOR_W-1:0] sh_all_color;
  logic [2**ID_W-1:0]              sh_all_blink;
  logic [COLOR_W-1:0]              act_rd_color;
  logic                            act_rd_blink;

  // Ports of each bank that this block has no use for.
  logic [COLOR_W-1:0]              sh_rd_color_unused;
  logic                            sh_rd_blink_unused;
  logic [2**ID_W-1:0][COLOR_W-1:0] act_all_color_unused;
  logic [2**ID_W-1:0]              act_all_blink_unused;

  // A commit in the frame_start cycle itself swaps immediately and never raises pending.
  assign swap = frame_start_i & (pending_q | commit_i);

  // Shadow bank: written by the host, copied wholesale into the active bank on swap.
  // The copy takes the registered shadow contents, so a write in the swap cycle
  // only lands in the shadow.
  palette_bank #(
    .ID_W     (ID_W),
    .COLOR_W  (COLOR_W),
    .BG_COLOR (BG_COLOR)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en_i),
    .wr_addr    (wr_addr_i),
    .wr_data    (wr_data_i),
    .wr_blink   (wr_blink_i),
    .load_en    (1'b0),
    .load_color ('0),
    .load_blink ('0),
    .rd_addr    (wr_addr_i),
    .rd_color   (sh_rd_color_unused),
    .rd_blink   (sh_rd_blink_unused),
    .all_color  (sh_all_color),
    .all_blink  (sh_all_blink)
  );

  // Active bank: only ever changed by the frame-boundary swap; read by stage 1.
  palette_bank #(
    .ID_W     (ID_W),
    .COLOR_W  (COLOR_W),
    .BG_COLOR (BG_COLOR)
  ) u_active (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (1'b0),
    .wr_addr    ('0),
    .wr_data    ('0),
    .wr_blink   (1'b0),
    .load_en    (swap),
    .load_color (sh_all_color),
    .load_blink (sh_all_blink),
    .rd_addr    (s1_id),
    .rd_color   (act_rd_color),
    .rd_blink   (act_rd_blink),
    .all_color  (act_all_color_unused),
    .all_blink  (act_all_blink_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if (swap) begin
      pending_q <= 1'b0;
    end else if (commit_i) begin
      pending_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= 8'd0;
      blink_phase <= 1'b0;
    end else if (frame_start_i) begin
      if (blink_cnt == CNT_MAX) begin
        blink_cnt   <= 8'd0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  // Stage 1: capture the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_id  <= '0;
    end else begin
      s1_vld <= pix_valid_i;
      s1_id  <= pix_id_i;
    end
  end

  // Stage 2: register the looked-up colour; output is forced to zero when not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_valid_o <= 1'b0;
      color_o       <= '0;
    end else begin
      color_valid_o <= s1_vld;
      if (!s1_vld)                           color_o <= '0;
      else if (blink_phase && act_rd_blink)  color_o <= BG_COLOR;
      else                                   color_o <= act_rd_color;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: doc/palette_lut.md
PALETTE_LUT -- requirements
Module: palette_lut

Interface
REQ-001 Parameter ID_W, default 4, width of colour index; palette depth SHALL be 2**ID_W entries.
REQ-002 Parameter COLOR_W, default 12, width of RGB colour word (4:4:4 at default).
REQ-003 Parameter BLINK_DIV, default 30, frame_start pulses per blink half-period, legal range 1..255.
REQ-004 Parameter BG_COLOR, default 12'h111, colour substituted for blinking entries in off phase.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 pix_valid_i  input  1  lookup request qualifier.
REQ-008 pix_id_i  input  ID_W  colour index to translate.
REQ-009 color_o  output  COLOR_W  translated colour.
REQ-010 color_valid_o  output  1  color_o qualifier.
REQ-011 wr_en_i  input  1  shadow palette write strobe.
REQ-012 wr_addr_i  input  ID_W  shadow entry index.
REQ-013 wr_data_i  input  COLOR_W  shadow entry colour.
REQ-014 wr_blink_i  input  1  shadow entry blink-enable bit.
REQ-015 commit_i  input  1  request shadow-to-active copy at next frame boundary.
REQ-016 frame_start_i  input  1  one-cycle pulse per video frame.
REQ-017 pending_o  output  1  commit requested, not yet applied.

Function
REQ-018 Lookup latency SHALL be exactly 2 cycles: stage 1 registers pix_valid_i/pix_id_i, stage 2 registers the looked-up colour and valid; one lookup per cycle, no stalls.
REQ-019 color_o SHALL be 0 whenever color_valid_o is 0.
REQ-020 Lookups SHALL read the active palette only; shadow writes never affect color_o before a commit.
REQ-021 wr_en_i SHALL update shadow colour and blink bit of entry wr_addr_i at the clock edge.
REQ-022 commit_i SHALL set pending; pending SHALL clear on the first frame_start_i at or after the commit cycle.
REQ-023 On frame_start_i with pending set (or commit_i in the same cycle) all entries SHALL copy shadow to active in one cycle.
REQ-024 Write and swap in the same cycle: swap copies pre-write shadow value; the write lands in shadow only.
REQ-025 commit_i while pending is already set SHALL have no additional effect.
REQ-026 Lookups in the swap cycle SHALL use pre-swap active palette at stage 1; next-cycle lookups use the new palette.
REQ-027 Blink counter SHALL count frame_start_i pulses 0..BLINK_DIV-1, wrap to 0, and toggle blink_phase on wrap.
REQ-028 When blink_phase=1 and the active entry's blink bit is 1, stage 2 SHALL output BG_COLOR instead of the entry colour.
REQ-029 Blink phase sampled at stage 2 register edge; phase change mid-frame impossible since it only changes on frame_start_i.

Reset
REQ-030 rst_n low SHALL asynchronously load shadow and active palettes with the default palette: 1=fff, 2=ccc, 3=0f0, 4=0c0, 5=ff0, 6=dd0, 7=f00, 8=d00, all others BG_COLOR; all blink bits 0.
REQ-031 Reset SHALL clear color_valid_o, color_o, pending_o, blink counter, blink_phase and pipeline valids.
REQ-032 Reset mid-lookup SHALL drop in-flight requests; no valid output emerges for them after release.

Structure
REQ-033 Shared package palette_pkg SHALL hold the default palette constant, default BG_COLOR and default widths.
REQ-034 Sub-module palette_bank (register array, one write port, one combinational read port, parallel load input, async reset to default) SHALL be instantiated twice: shadow and active.

Verification
REQ-035 Post-reset, ids 0..15 in consecutive cycles -> colours fff,ccc,... per REQ-030 appear two cycles later, id 0 and 9..15 give 111.
REQ-036 Write id3=abc, no commit, lookup id3 -> 0f0; commit then frame_start, lookup id3 -> abc; pending_o high exactly from commit+1 to swap cycle+1.
REQ-037 commit_i and frame_start_i same cycle with wr_en_i id5=123 -> active id5 keeps prior shadow value; second commit+frame_start -> 123.
REQ-038 BLINK_DIV=2, id7 blink=1 committed, continuous lookups id7 -> f00 for 2 frames, 111 for 2 frames, repeating; id8 (no blink) stays d00.
REQ-039 Assert rst_n low mid-stream with pending set and palette modified -> outputs zero immediately, pending_o 0, palette back to defaults, no stale valid after release.
